// File: rtl/btn_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_multi
// Description : Multi-channel push-button conditioner. Each channel has its
//               own synchroniser, counter-based stability filter, debounced
//               level register, rise/fall pulses and a press pulse with
//               optional auto-repeat while the button is held.
// Ports       : clk_in    - system clock, all logic on rising edge
//               rst       - asynchronous, active-low reset
//               btn_in    - raw asynchronous button inputs  [CHANNELS]
//               btn_level - debounced level                 [CHANNELS]
//               btn_rise  - 1-cycle pulse on level 0->1     [CHANNELS]
//               btn_fall  - 1-cycle pulse on level 1->0     [CHANNELS]
//               btn_press - 1-cycle pulse on rise and on each repeat [CHANNELS]
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_press
);

    localparam int c_stab_w = $clog2((STABLE_CYCLES > 2) ? STABLE_CYCLES : 2);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 1);
    localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_stab_w-1:0]    r_stab_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_press;
        logic                   w_sync;
        logic                   w_accept;
        logic                   w_press_next;

        assign w_sync = r_sync[SYNC_STAGES-1];

        // The synchronised input has disagreed with the level for
        // STABLE_CYCLES consecutive edges, including this one.
        assign w_accept = (w_sync != r_level) && (r_stab_cnt == c_stab_last);

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                r_sync     <= '0;
                r_stab_cnt <= '0;
                r_level    <= 1'b0;
                r_rise     <= 1'b0;
                r_fall     <= 1'b0;
                r_press    <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[i]};

                // Any agreement restarts the count, so a bounce anywhere in
                // the window forces a full new stable interval.
                if ((w_sync == r_level) || w_accept) begin
                    r_stab_cnt <= '0;
                end else begin
                    r_stab_cnt <= r_stab_cnt + c_stab_one;
                end

                if (w_accept) begin
                    r_level <= w_sync;
                end
                r_rise  <= w_accept && w_sync;
                r_fall  <= w_accept && !w_sync;
                r_press <= w_press_next;
            end
        end

        if (REPEAT_DELAY > 0) begin : g_rep
            localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int c_rep_w   = $clog2((c_rep_max > 2) ? c_rep_max : 2);
            localparam logic [c_rep_w-1:0] c_dly_last = c_rep_w'(REPEAT_DELAY - 1);
            localparam logic [c_rep_w-1:0] c_per_last = c_rep_w'(REPEAT_PERIOD - 1);
            localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);

            logic [c_rep_w-1:0] r_rep_cnt;
            logic               r_rep_phase;   // 0: initial delay, 1: periodic repeat
            logic               w_rep_hit;

            // A repeat never fires on the edge that accepts the release, so a
            // fall is never accompanied by a press.
            assign w_rep_hit = r_level && !w_accept &&
                               (r_rep_cnt == (r_rep_phase ? c_per_last : c_dly_last));

            // Counter reloads to zero on every hit, so it can never wrap
            // through the compare value and fire a spurious press.
            always_ff @(posedge clk_in or negedge rst) begin
                if (!rst) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b0;
                end else if (!r_level || w_accept) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b0;
                end else if (w_rep_hit) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b1;
                end else begin
                    r_rep_cnt   <= r_rep_cnt + c_rep_one;
                end
            end

            assign w_press_next = (w_accept && w_sync) || w_rep_hit;
        end else begin : g_no_rep
            assign w_press_next = w_accept && w_sync;
        end

        assign btn_level[i] = r_level;
        assign btn_rise[i]  = r_rise;
        assign btn_fall[i]  = r_fall;
        assign btn_press[i] = r_press;
    end

endmodule
`default_nettype wire
